// File: rtl/pipeline_elastic.sv
// pipeline_elastic: p_stages-deep elastic register pipeline with per-stage valid/ready,
// synchronous flush and a registered occupancy count.
module pipeline_elastic #(
   parameter  int p_width  = 32,
   parameter  int p_stages = 8,
   localparam int p_cnt_w  = $clog2(p_stages + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [p_width-1:0] i_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [p_width-1:0] o_data,
   output logic [p_cnt_w-1:0] o_count
);
   logic [p_stages-1:0] v_q, v_d, rdy, up_v;
   logic [p_width-1:0]  d_q [p_stages];
   logic [p_width-1:0]  d_d [p_stages];
   logic [p_width-1:0]  up_d [p_stages];
   logic [p_cnt_w-1:0]  count_q, count_d;
   logic                r, in_x, out_x;
   // a stage may advance when any stage at or beyond it is empty, or the sink accepts
   always_comb begin
      r = i_ready;
      rdy = '0;
      for (int k = p_stages - 1; k >= 0; k--) begin
         r = r | ~v_q[k];
         rdy[k] = r;
      end
      up_v[0] = i_valid;
      up_d[0] = i_data;
      for (int k = 1; k < p_stages; k++) begin
         up_v[k] = v_q[k-1];
         up_d[k] = d_q[k-1];
      end
      for (int k = 0; k < p_stages; k++) begin
         v_d[k] = i_flush ? 1'b0 : rdy[k] ? up_v[k] : v_q[k];
         d_d[k] = (rdy[k] && up_v[k] && !i_flush) ? up_d[k] : d_q[k];
      end
      o_ready = rdy[0] & ~i_flush & i_rst_n;
      o_valid = v_q[p_stages-1] & ~i_flush;
      in_x    = i_valid & o_ready;
      out_x   = o_valid & i_ready;
      count_d = i_flush ? '0 : count_q + p_cnt_w'(in_x) - p_cnt_w'(out_x);
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v_q     <= '0;
         count_q <= '0;
         for (int k = 0; k < p_stages; k++) d_q[k] <= '0;
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
         for (int k = 0; k < p_stages; k++) d_q[k] <= d_d[k];
      end
   end
   assign o_data  = d_q[p_stages-1];
   assign o_count = count_q;
endmodule

// File: tb/tb_pipeline_elastic.sv
// tb_pipeline_elastic: directed scenarios plus random traffic, checked every cycle
// against a slot-level behavioural model of the elastic pipeline.
module tb_pipeline_elastic;
   logic       i_clk = 0, i_rst_n = 0, i_flush = 0, i_valid = 0, i_ready = 0;
   logic [7:0] i_data = 0;
   logic       o_ready, o_valid;
   logic [7:0] o_data;
   logic [2:0] o_count;
   int         tests = 0, fails = 0, stepn = 0, acc;
   bit         s_valid, s_ready;
   logic [7:0] s_data;
   int         s_count;
   logic [7:0] out_q[$];
   int         out_t[$];
   bit         mv[4];
   logic [7:0] md[4];
   bit         mr[4];

   pipeline_elastic #(.p_width(8), .p_stages(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(o_ready), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_count(o_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // model: a stage moves when the sink is ready or any slot at/after it is empty
   always @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         foreach (mv[k]) begin mv[k] = 0; md[k] = 0; end
      end else begin
         int c;
         c = 0;
         foreach (mv[k]) begin
            mr[k] = i_ready;
            for (int j = k; j < 4; j++) if (!mv[j]) mr[k] = 1;
            if (mv[k]) c++;
         end
         chk("model_ready", o_ready, mr[0] && !i_flush);
         chk("model_valid", o_valid, mv[3] && !i_flush);
         chk("model_data", o_data, md[3]);
         chk("model_count", o_count, c);
         if (i_flush) foreach (mv[k]) mv[k] = 0;
         else
            for (int k = 3; k >= 0; k--)
               if (mr[k]) begin
                  bit uv;
                  uv = (k == 0) ? i_valid : mv[k-1];
                  if (uv) md[k] = (k == 0) ? i_data : md[k-1];
                  mv[k] = uv;
               end
      end
   end

   task automatic step(input bit iv, input logic [7:0] id, input bit ir, input bit fl);
      i_valid = iv; i_data = id; i_ready = ir; i_flush = fl;
      @(negedge i_clk);
      s_valid = o_valid; s_ready = o_ready; s_data = o_data; s_count = int'(o_count);
      if (o_valid && i_ready) begin out_q.push_back(o_data); out_t.push_back(stepn); end
      stepn++;
      @(posedge i_clk); #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 1, 0);
   endtask

   initial begin
      #3;
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_count", o_count, 0);
      @(posedge i_clk); #1 i_rst_n = 1;
      // fill and stream 0x01..0x08
      for (int i = 0; i < 8; i++) begin
         step(1, 8'(i + 1), 1, 0);
         if (i == 0) chk("first_ready", s_ready, 1);
         if (i == 3) chk("lat_not_yet", s_valid, 0);
         if (i == 4) begin
            chk("lat_valid", s_valid, 1);
            chk("lat_data", s_data, 8'h01);
            chk("steady_count", s_count, 4);
         end
      end
      drain(6);
      chk("fill_n", out_q.size(), 8);
      foreach (out_q[i]) chk("fill_order", out_q[i], i + 1);
      if (out_q.size() == 8) chk("fill_consec", out_t[7] - out_t[0], 7);
      // backpressure fill
      out_q.delete(); out_t.delete(); acc = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 8'(8'h10 + acc), 0, 0);
         if (s_ready) acc++;
      end
      chk("bp_accepts", acc, 4);
      chk("bp_ready", s_ready, 0);
      chk("bp_count", s_count, 4);
      // full pass-through
      step(1, 8'h14, 1, 0);
      chk("pt_ready", s_ready, 1);
      chk("pt_valid", s_valid, 1);
      chk("pt_data", s_data, 8'h10);
      step(0, 8'h00, 0, 0);
      chk("pt_count", s_count, 4);
      drain(6);
      chk("bp_n", out_q.size(), 5);
      foreach (out_q[i]) chk("bp_order", out_q[i], 8'h10 + i);
      // bubble collapse
      out_q.delete(); out_t.delete();
      step(1, 8'h20, 0, 0);
      step(0, 8'h00, 0, 0);
      step(0, 8'h00, 0, 0);
      step(1, 8'h21, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);
      chk("bub_count", s_count, 2);
      chk("bub_head", s_data, 8'h20);
      chk("bub_stage2", int'(dut.d_q[2]), 8'h21);
      drain(4);
      chk("bub_n", out_q.size(), 2);
      if (out_q.size() == 2) begin
         chk("bub_w0", out_q[0], 8'h20);
         chk("bub_w1", out_q[1], 8'h21);
         chk("bub_consec", out_t[1] - out_t[0], 1);
      end
      // flush with three words in flight
      out_q.delete(); out_t.delete();
      for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0);
      step(1, 8'h33, 1, 1);
      chk("fl_ready", s_ready, 0);
      chk("fl_valid", s_valid, 0);
      step(0, 8'h00, 1, 0);
      chk("fl_count", s_count, 0);
      chk("fl_valid_after", s_valid, 0);
      drain(5);
      chk("fl_no_out", out_q.size(), 0);
      // async reset mid-stream
      for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
      chk("ar_full", s_count, 4);
      i_valid = 0;
      @(negedge i_clk); #2 i_rst_n = 0;
      #1;
      chk("ar_valid", o_valid, 0);
      chk("ar_count", o_count, 0);
      chk("ar_ready", o_ready, 0);
      chk("ar_data", o_data, 0);
      @(posedge i_clk); #1 i_rst_n = 1;
      out_q.delete(); out_t.delete();
      drain(1);
      chk("ar_rel_ready", s_ready, 1);
      drain(5);
      chk("ar_idle", out_q.size(), 0);
      step(1, 8'h50, 1, 0);
      drain(5);
      chk("ar_new_n", out_q.size(), 1);
      if (out_q.size() == 1) chk("ar_new_w", out_q[0], 8'h50);
      // random traffic
      for (int i = 0; i < 800; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
